// File: rtl/sipo_256bit_pkg.sv
// Shared constants and types for the 10-bit pixel to 256-bit word packer.
package sipo_256bit_pkg;

    localparam int DATA_W       = 10;
    localparam int OUT_W        = 256;
    localparam int PIX_PER_WORD = OUT_W / DATA_W;

    typedef logic [4:0]        slot_idx_t;
    typedef logic [DATA_W-1:0] pixel_t;
    typedef logic [OUT_W-1:0]  word_t;

    localparam slot_idx_t SLOT_ZERO = 5'd0;
    localparam slot_idx_t SLOT_ONE  = 5'd1;
    localparam slot_idx_t LAST_SLOT = slot_idx_t'(PIX_PER_WORD - 1);
    localparam word_t     WORD_ZERO = {OUT_W{1'b0}};

endpackage : sipo_256bit_pkg

// File: rtl/sipo_256bit_if.sv
// Pixel stream in, packed word out. The producer/consumer side is the master,
// the packer is the slave.
interface sipo_256bit_if;
    import sipo_256bit_pkg::*;

    logic   SIPO_en;
    pixel_t SIPO_in;
    logic   force_rdy;
    logic   SIPO_rdy;
    word_t  SIPO_out;

    modport master (
        output SIPO_en,
        output SIPO_in,
        output force_rdy,
        input  SIPO_rdy,
        input  SIPO_out
    );

    modport slave (
        input  SIPO_en,
        input  SIPO_in,
        input  force_rdy,
        output SIPO_rdy,
        output SIPO_out
    );

endinterface : sipo_256bit_if

// File: rtl/sipo_256bit.sv
// Serial-in/parallel-out packer: 25 LSB-first 10-bit pixels per 256-bit word,
// with an early flush for the partial word at frame end. Emission happens on
// the same edge that stores the closing pixel; bits above slot 24 stay zero.
module sipo_256bit
    import sipo_256bit_pkg::*;
(
    input  logic          clk,
    input  logic          nrst,
    sipo_256bit_if.slave  sipo
);

    slot_idx_t  idx_q;
    slot_idx_t  idx_d;
    word_t      buf_q;
    word_t      buf_d;
    word_t      out_q;
    word_t      out_d;
    logic       rdy_q;
    logic       rdy_d;

    word_t      wr_buf_s;
    logic [7:0] base_s;
    logic       emit_s;

    // Buffer contents as they would look with the incoming pixel in its slot
    always_comb begin
        wr_buf_s = buf_q;
        base_s   = 8'(idx_q) * 8'(DATA_W);
        if (sipo.SIPO_en) begin
            wr_buf_s[base_s +: DATA_W] = sipo.SIPO_in;
        end else begin
            wr_buf_s = buf_q;
        end
    end

    // Emission decision and next-state for index, buffer and output word
    always_comb begin
        idx_d  = idx_q;
        buf_d  = buf_q;
        out_d  = out_q;
        rdy_d  = 1'b0;
        emit_s = 1'b0;

        // A forced flush with no new pixel only fires for a non-empty word,
        // so a held force_rdy cannot produce repeated or empty words.
        if (sipo.SIPO_en) begin
            emit_s = (idx_q >= LAST_SLOT) || sipo.force_rdy;
        end else begin
            emit_s = sipo.force_rdy && (idx_q != SLOT_ZERO);
        end

        if (emit_s) begin
            out_d = wr_buf_s;
            rdy_d = 1'b1;
            idx_d = SLOT_ZERO;
            buf_d = WORD_ZERO;
        end else if (sipo.SIPO_en) begin
            buf_d = wr_buf_s;
            idx_d = idx_q + SLOT_ONE;
        end else begin
            idx_d = idx_q;
            buf_d = buf_q;
        end
    end

    // State registers; reset discards any partial word without emitting it
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            idx_q <= SLOT_ZERO;
            buf_q <= WORD_ZERO;
            out_q <= WORD_ZERO;
            rdy_q <= 1'b0;
        end else begin
            idx_q <= idx_d;
            buf_q <= buf_d;
            out_q <= out_d;
            rdy_q <= rdy_d;
        end
    end

    assign sipo.SIPO_rdy = rdy_q;
    assign sipo.SIPO_out = out_q;

endmodule : sipo_256bit

// File: tb/tb_sipo_256bit.sv
// Self-checking bench for sipo_256bit. The reference model keeps the pixels of
// the open word in a queue and packs them whenever 25 are held or a flush is
// requested on a non-empty word.
module tb_sipo_256bit;
    import sipo_256bit_pkg::*;

    logic clk = 1'b0;
    logic nrst;
    int   total = 0;
    int   bad   = 0;

    sipo_256bit_if sif();

    sipo_256bit dut (
        .clk  (clk),
        .nrst (nrst),
        .sipo (sif.slave)
    );

    always #5 clk = ~clk;

    pixel_t pend[$];
    word_t  exp_out;
    logic   exp_rdy;

    function automatic word_t pack_pending();
        word_t w;
        w = WORD_ZERO;
        for (int k = 0; k < pend.size(); k++) begin
            w[k*DATA_W +: DATA_W] = pend[k];
        end
        return w;
    endfunction

    task automatic model_reset();
        pend.delete();
        exp_out = WORD_ZERO;
        exp_rdy = 1'b0;
    endtask

    // Drive one cycle of inputs, advance past the edge, update the model
    task automatic step(input logic en, input pixel_t din, input logic frc);
        sif.SIPO_en   = en;
        sif.SIPO_in   = din;
        sif.force_rdy = frc;
        @(posedge clk);
        #1;
        exp_rdy = 1'b0;
        if (en) pend.push_back(din);
        if (pend.size() == PIX_PER_WORD || (frc && pend.size() > 0)) begin
            exp_out = pack_pending();
            exp_rdy = 1'b1;
            pend.delete();
        end
    endtask

    task automatic test_reset();
        nrst = 1'b0;
        sif.SIPO_en = 1'b0; sif.SIPO_in = 10'd0; sif.force_rdy = 1'b0;
        #12;
        total++; if (sif.SIPO_rdy !== 1'b0) begin bad++; $display("FAIL reset_rdy got=%0b want=0", sif.SIPO_rdy); end
        total++; if (sif.SIPO_out !== WORD_ZERO) begin bad++; $display("FAIL reset_out got=%h want=0", sif.SIPO_out); end
        sif.SIPO_en = 1'b1; sif.SIPO_in = 10'h3FF; sif.force_rdy = 1'b1;
        @(posedge clk); #1;
        total++; if (sif.SIPO_rdy !== 1'b0) begin bad++; $display("FAIL reset_hold_rdy got=%0b want=0", sif.SIPO_rdy); end
        total++; if (sif.SIPO_out !== WORD_ZERO) begin bad++; $display("FAIL reset_hold_out got=%h want=0", sif.SIPO_out); end
        sif.SIPO_en = 1'b0; sif.force_rdy = 1'b0;
        @(negedge clk);
        nrst = 1'b1;
        model_reset();
    endtask

    task automatic test_ramp();
        for (int i = 0; i < 50; i++) begin
            step(1'b1, pixel_t'(i), 1'b0);
            total++; if (sif.SIPO_rdy !== exp_rdy) begin bad++; $display("FAIL ramp_rdy i=%0d got=%0b want=%0b", i, sif.SIPO_rdy, exp_rdy); end
            total++; if (sif.SIPO_out !== exp_out) begin bad++; $display("FAIL ramp_out i=%0d got=%h want=%h", i, sif.SIPO_out, exp_out); end
            if (i == 24) begin
                total++; if (sif.SIPO_rdy !== 1'b1) begin bad++; $display("FAIL ramp_first_pulse got=%0b want=1", sif.SIPO_rdy); end
                total++; if (sif.SIPO_out[9:0] !== 10'h000) begin bad++; $display("FAIL ramp_slot0 got=%h want=000", sif.SIPO_out[9:0]); end
                total++; if (sif.SIPO_out[19:10] !== 10'h001) begin bad++; $display("FAIL ramp_slot1 got=%h want=001", sif.SIPO_out[19:10]); end
                total++; if (sif.SIPO_out[249:240] !== 10'h018) begin bad++; $display("FAIL ramp_slot24 got=%h want=018", sif.SIPO_out[249:240]); end
                total++; if (sif.SIPO_out[255:250] !== 6'd0) begin bad++; $display("FAIL ramp_pad got=%h want=0", sif.SIPO_out[255:250]); end
            end
            if (i == 49) begin
                total++; if (sif.SIPO_out[9:0] !== 10'h019) begin bad++; $display("FAIL ramp_word2_slot0 got=%h want=019", sif.SIPO_out[9:0]); end
            end
        end
    endtask

    task automatic test_continuous();
        int pulses;
        int last;
        pulses = 0;
        last   = -1;
        for (int i = 0; i < 100; i++) begin
            step(1'b1, pixel_t'($urandom), 1'b0);
            total++; if (sif.SIPO_rdy !== exp_rdy) begin bad++; $display("FAIL cont_rdy i=%0d got=%0b want=%0b", i, sif.SIPO_rdy, exp_rdy); end
            total++; if (sif.SIPO_out !== exp_out) begin bad++; $display("FAIL cont_out i=%0d got=%h want=%h", i, sif.SIPO_out, exp_out); end
            if (sif.SIPO_rdy === 1'b1) begin
                pulses++;
                if (last >= 0) begin
                    total++; if (i - last !== 25) begin bad++; $display("FAIL cont_spacing got=%0d want=25", i - last); end
                end
                last = i;
            end
        end
        total++; if (pulses !== 4) begin bad++; $display("FAIL cont_pulses got=%0d want=4", pulses); end
    endtask

    task automatic test_gap();
        for (int i = 0; i < 12; i++) begin
            step(1'b1, pixel_t'($urandom), 1'b0);
            total++; if (sif.SIPO_rdy !== 1'b0) begin bad++; $display("FAIL gap_pre_rdy i=%0d got=%0b want=0", i, sif.SIPO_rdy); end
        end
        for (int i = 0; i < 10; i++) begin
            step(1'b0, pixel_t'($urandom), 1'b0);
            total++; if (sif.SIPO_rdy !== 1'b0) begin bad++; $display("FAIL gap_idle_rdy i=%0d got=%0b want=0", i, sif.SIPO_rdy); end
        end
        for (int i = 0; i < 13; i++) begin
            step(1'b1, pixel_t'($urandom), 1'b0);
            total++; if (sif.SIPO_rdy !== exp_rdy) begin bad++; $display("FAIL gap_post_rdy i=%0d got=%0b want=%0b", i, sif.SIPO_rdy, exp_rdy); end
        end
        total++; if (sif.SIPO_rdy !== 1'b1) begin bad++; $display("FAIL gap_complete got=%0b want=1", sif.SIPO_rdy); end
        total++; if (sif.SIPO_out !== exp_out) begin bad++; $display("FAIL gap_word got=%h want=%h", sif.SIPO_out, exp_out); end
    endtask

    task automatic test_force_idle();
        pixel_t p[3];
        step(1'b0, 10'd0, 1'b1);
        total++; if (sif.SIPO_rdy !== 1'b0) begin bad++; $display("FAIL force_empty_rdy got=%0b want=0", sif.SIPO_rdy); end
        for (int i = 0; i < 3; i++) begin
            p[i] = pixel_t'($urandom);
            step(1'b1, p[i], 1'b0);
        end
        for (int c = 0; c < 3; c++) begin
            step(1'b0, 10'd0, 1'b1);
            total++; if (sif.SIPO_rdy !== (c == 0)) begin bad++; $display("FAIL force_held_rdy c=%0d got=%0b want=%0b", c, sif.SIPO_rdy, (c == 0)); end
        end
        total++; if (sif.SIPO_out[29:0] !== {p[2], p[1], p[0]}) begin bad++; $display("FAIL force_slots got=%h want=%h", sif.SIPO_out[29:0], {p[2], p[1], p[0]}); end
        total++; if (sif.SIPO_out[255:30] !== 226'd0) begin bad++; $display("FAIL force_zero_fill got=%h want=0", sif.SIPO_out[255:30]); end
        // Next word: force on the 25th pixel must give a single pulse
        for (int i = 0; i < 25; i++) begin
            step(1'b1, pixel_t'($urandom), (i == 24));
            total++; if (sif.SIPO_rdy !== exp_rdy) begin bad++; $display("FAIL force_last_rdy i=%0d got=%0b want=%0b", i, sif.SIPO_rdy, exp_rdy); end
            total++; if (sif.SIPO_out !== exp_out) begin bad++; $display("FAIL force_last_out i=%0d got=%h want=%h", i, sif.SIPO_out, exp_out); end
        end
        step(1'b0, 10'd0, 1'b1);
        total++; if (sif.SIPO_rdy !== 1'b0) begin bad++; $display("FAIL force_no_double got=%0b want=0", sif.SIPO_rdy); end
        sif.force_rdy = 1'b0;
    endtask

    task automatic test_frame();
        int pulses;
        pixel_t want;
        pulses = 0;
        for (int n = 0; n < 16384; n++) begin
            step(1'b1, pixel_t'(n), (n == 16383));
            if (sif.SIPO_rdy === 1'b1) pulses++;
            total++; if (sif.SIPO_rdy !== exp_rdy) begin bad++; $display("FAIL frame_rdy n=%0d got=%0b want=%0b", n, sif.SIPO_rdy, exp_rdy); end
            total++; if (sif.SIPO_out !== exp_out) begin bad++; $display("FAIL frame_out n=%0d got=%h want=%h", n, sif.SIPO_out, exp_out); end
        end
        total++; if (pulses !== 656) begin bad++; $display("FAIL frame_pulses got=%0d want=656", pulses); end
        for (int k = 0; k < PIX_PER_WORD; k++) begin
            want = (k < 9) ? pixel_t'(16375 + k) : 10'd0;
            total++; if (sif.SIPO_out[k*DATA_W +: DATA_W] !== want) begin bad++; $display("FAIL frame_last_slot k=%0d got=%h want=%h", k, sif.SIPO_out[k*DATA_W +: DATA_W], want); end
        end
        total++; if (sif.SIPO_out[255:250] !== 6'd0) begin bad++; $display("FAIL frame_pad got=%h want=0", sif.SIPO_out[255:250]); end
        sif.force_rdy = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            step(($urandom % 4) != 0, pixel_t'($urandom), ($urandom % 8) == 0);
            total++; if (sif.SIPO_rdy !== exp_rdy) begin bad++; $display("FAIL rand_rdy i=%0d got=%0b want=%0b", i, sif.SIPO_rdy, exp_rdy); end
            total++; if (sif.SIPO_out !== exp_out) begin bad++; $display("FAIL rand_out i=%0d got=%h want=%h", i, sif.SIPO_out, exp_out); end
        end
    endtask

    task automatic test_async_reset();
        pixel_t first;
        // Close any open word, then open a new one at slot 7
        for (int i = 0; i < PIX_PER_WORD && pend.size() != 0; i++) begin
            step(1'b1, pixel_t'($urandom) | 10'd1, 1'b0);
        end
        for (int i = 0; i < 7; i++) step(1'b1, pixel_t'($urandom) | 10'd1, 1'b0);
        sif.SIPO_en = 1'b0;
        #2;
        nrst = 1'b0;
        #1;
        total++; if (sif.SIPO_rdy !== 1'b0) begin bad++; $display("FAIL arst_rdy got=%0b want=0", sif.SIPO_rdy); end
        total++; if (sif.SIPO_out !== WORD_ZERO) begin bad++; $display("FAIL arst_out got=%h want=0", sif.SIPO_out); end
        @(negedge clk);
        nrst = 1'b1;
        model_reset();
        first = pixel_t'($urandom);
        for (int i = 0; i < 25; i++) begin
            step(1'b1, (i == 0) ? first : pixel_t'($urandom), 1'b0);
            total++; if (sif.SIPO_rdy !== exp_rdy) begin bad++; $display("FAIL arst_post_rdy i=%0d got=%0b want=%0b", i, sif.SIPO_rdy, exp_rdy); end
        end
        total++; if (sif.SIPO_out !== exp_out) begin bad++; $display("FAIL arst_post_out got=%h want=%h", sif.SIPO_out, exp_out); end
        total++; if (sif.SIPO_out[9:0] !== first) begin bad++; $display("FAIL arst_slot0 got=%h want=%h", sif.SIPO_out[9:0], first); end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_ramp();
        test_continuous();
        test_gap();
        test_force_idle();
        test_frame();
        test_random();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_sipo_256bit
